// File: rtl/uart_pkg.sv
// Shared constants and bit-FSM state encoding for the UART packet receiver.
package uart_pkg;

  localparam int PAR_NONE   = 0;
  localparam int PAR_EVEN   = 1;
  localparam int PAR_ODD    = 2;
  localparam int FIFO_DEPTH = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } bit_state_t;

endpackage

// File: rtl/uart_rx_bit.sv
// UART bit layer: rxd synchronizer, mid-bit sampling and frame FSM.
// Strobe outputs are combinational and asserted in the sample cycle.
module uart_rx_bit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = PAR_NONE
) (
  input  logic       writeClk,
  input  logic       reset,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       line_idle
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1, sync2, rx_prev;
  bit_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bad, par_bad_n;
  logic          brk, brk_n;
  logic          par_exp;

  always_ff @(posedge writeClk) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
      brk     <= 1'b0;
    end else begin
      sync1   <= rxd;
      sync2   <= sync1;
      rx_prev <= sync2;
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      par_bad <= par_bad_n;
      brk     <= brk_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + CW'(1);
    idx_n      = idx;
    shreg_n    = shreg;
    par_bad_n  = par_bad;
    brk_n      = brk;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    par_exp    = (^shreg) ^ (PARITY == PAR_ODD);

    unique case (state)
      ST_IDLE: begin
        cnt_n     = '0;
        par_bad_n = 1'b0;
        brk_n     = 1'b0;
        if (rx_prev && !sync2) state_n = ST_START;
      end
      ST_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = sync2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          shreg_n = {sync2, shreg[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
        end
      end
      ST_PAR: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          state_n = ST_STOP;
          if (sync2 != par_exp) begin
            par_bad_n  = 1'b1;
            parity_err = 1'b1;
          end
        end
      end
      ST_STOP: begin
        // After a framing error, park here until the line returns high.
        if (brk) begin
          cnt_n = '0;
          if (sync2) state_n = ST_IDLE;
        end else if (cnt == FULL_LAST) begin
          cnt_n = '0;
          if (sync2) begin
            byte_valid = !par_bad;
            state_n    = ST_IDLE;
          end else begin
            frame_err = 1'b1;
            brk_n     = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign data      = shreg;
  assign line_idle = (state == ST_IDLE) && sync2;

endmodule

// File: rtl/uart_rx_packet_writer.sv
// Packet layer over the UART bit receiver: speculative FIFO writes,
// commit on a clean idle gap, single rollback on the first error.
module uart_rx_packet_writer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int IDLE_BITS    = 12,
  parameter int MAX_PKT      = 2048
) (
  input  logic       writeClk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       almostFull,
  output logic [8:0] dataIn,
  output logic       writeEn,
  output logic       commitWrite,
  output logic       rollbackWrite,
  output logic       pktDone,
  output logic       pktDropped,
  output logic       frameErr,
  output logic       parityErr,
  output logic       busy
);

  localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int ICW        = $clog2(IDLE_LIMIT + 1);
  localparam int BCW        = $clog2(FIFO_DEPTH);

  logic           byte_valid, fe, pe, line_idle;
  logic [7:0]     rx_byte;
  logic [BCW-1:0] byte_cnt;
  logic [ICW-1:0] idle_cnt;
  logic           discard;
  logic           over_len, err, idle_end;

  uart_rx_bit #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .PARITY      (PARITY)
  ) u_bit (
    .writeClk  (writeClk),
    .reset     (reset),
    .rxd       (rxd),
    .byte_valid(byte_valid),
    .data      (rx_byte),
    .frame_err (fe),
    .parity_err(pe),
    .line_idle (line_idle)
  );

  always_comb begin
    over_len = (byte_cnt == BCW'(MAX_PKT));
    err      = fe || pe || (byte_valid && (almostFull || over_len));
    idle_end = line_idle && (idle_cnt == ICW'(IDLE_LIMIT - 1));
  end

  // Errors and byte writes happen in bit-FSM sample cycles, idle_end only
  // while the FSM idles, so the three branches below never coincide.
  always_ff @(posedge writeClk) begin
    if (reset) begin
      dataIn        <= '0;
      writeEn       <= 1'b0;
      commitWrite   <= 1'b0;
      rollbackWrite <= 1'b0;
      pktDone       <= 1'b0;
      pktDropped    <= 1'b0;
      frameErr      <= 1'b0;
      parityErr     <= 1'b0;
      busy          <= 1'b0;
      discard       <= 1'b0;
      byte_cnt      <= '0;
      idle_cnt      <= '0;
    end else begin
      writeEn       <= 1'b0;
      commitWrite   <= 1'b0;
      rollbackWrite <= 1'b0;
      pktDone       <= 1'b0;
      pktDropped    <= 1'b0;
      frameErr      <= fe;
      parityErr     <= pe;

      if (!line_idle)                           idle_cnt <= '0;
      else if (idle_cnt != ICW'(IDLE_LIMIT))    idle_cnt <= idle_cnt + ICW'(1);

      if (err && !discard) begin
        rollbackWrite <= 1'b1;
        pktDropped    <= 1'b1;
        discard       <= 1'b1;
        busy          <= 1'b1;
      end else if (byte_valid && !discard) begin
        writeEn  <= 1'b1;
        dataIn   <= {!busy, rx_byte};
        byte_cnt <= byte_cnt + BCW'(1);
        busy     <= 1'b1;
      end else if (idle_end && busy) begin
        commitWrite <= !discard;
        pktDone     <= !discard;
        busy        <= 1'b0;
        discard     <= 1'b0;
        byte_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packet_writer.sv
// Directed/random bench: two receivers (8N1 with short MAX_PKT, 8E1) checked
// against a packet-level reference model of expected writes and outcomes.
module tb_uart_rx_packet_writer;

  localparam int CPB      = 16;
  localparam int IDLE_B   = 12;
  localparam int IDLE_GAP = IDLE_B * CPB;
  localparam int MAXP0    = 6;
  localparam int MAXP1    = 2048;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] rxd = 2'b11;
  logic [1:0] af = 2'b00;
  logic [8:0] din [2];
  logic [1:0] we, cm, rb, dn, dr, fe, pe, bz;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_packet_writer #(
    .CLKS_PER_BIT(CPB), .PARITY(0), .IDLE_BITS(IDLE_B), .MAX_PKT(MAXP0)
  ) dut0 (
    .writeClk(clk), .reset(reset), .rxd(rxd[0]), .almostFull(af[0]),
    .dataIn(din[0]), .writeEn(we[0]), .commitWrite(cm[0]), .rollbackWrite(rb[0]),
    .pktDone(dn[0]), .pktDropped(dr[0]), .frameErr(fe[0]), .parityErr(pe[0]),
    .busy(bz[0])
  );

  uart_rx_packet_writer #(
    .CLKS_PER_BIT(CPB), .PARITY(1), .IDLE_BITS(IDLE_B), .MAX_PKT(MAXP1)
  ) dut1 (
    .writeClk(clk), .reset(reset), .rxd(rxd[1]), .almostFull(af[1]),
    .dataIn(din[1]), .writeEn(we[1]), .commitWrite(cm[1]), .rollbackWrite(rb[1]),
    .pktDone(dn[1]), .pktDropped(dr[1]), .frameErr(fe[1]), .parityErr(pe[1]),
    .busy(bz[1])
  );

  // Output monitor: event counts, captured writes, pairwise exclusivity rules.
  logic [8:0] wq0[$], wq1[$];
  int n_cm[2] = '{0, 0}, n_rb[2] = '{0, 0}, n_dn[2] = '{0, 0}, n_dr[2] = '{0, 0};
  int n_fe[2] = '{0, 0}, n_pe[2] = '{0, 0}, last_we[2] = '{0, 0}, last_cm[2] = '{0, 0};
  int viol = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we[i] === 1'b1) begin
        if (i == 0) wq0.push_back(din[0]);
        else        wq1.push_back(din[1]);
        last_we[i] <= cyc;
      end
      if (cm[i] === 1'b1) begin n_cm[i] <= n_cm[i] + 1; last_cm[i] <= cyc; end
      if (rb[i] === 1'b1) n_rb[i] <= n_rb[i] + 1;
      if (dn[i] === 1'b1) n_dn[i] <= n_dn[i] + 1;
      if (dr[i] === 1'b1) n_dr[i] <= n_dr[i] + 1;
      if (fe[i] === 1'b1) n_fe[i] <= n_fe[i] + 1;
      if (pe[i] === 1'b1) n_pe[i] <= n_pe[i] + 1;
      if ((cm[i] & rb[i]) || (we[i] & (cm[i] | rb[i])) ||
          (dn[i] !== cm[i]) || (dr[i] !== rb[i]))
        viol <= viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input int inst, input logic v);
    rxd[inst] = v;
    repeat (CPB) @(negedge clk);
  endtask

  // kind: 0 good, 1 wrong parity bit, 2 stop held low 3 bit-times, 3 almostFull
  task automatic send_frame(input int inst, input logic [7:0] b, input int kind);
    logic p;
    if (kind == 3) af[inst] = 1'b1;
    drive_bit(inst, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(inst, b[i]);
    if (inst == 1) begin
      p = ^b;
      if (kind == 1) p = ~p;
      drive_bit(inst, p);
    end
    if (kind == 2) repeat (3) drive_bit(inst, 1'b0);
    drive_bit(inst, 1'b1);
    af[inst] = 1'b0;
  endtask

  logic [7:0] pb[$];
  int         pk[$];

  function automatic int qsize(input int inst);
    return (inst == 0) ? wq0.size() : wq1.size();
  endfunction

  function automatic logic [8:0] qat(input int inst, input int j);
    return (inst == 0) ? wq0[j] : wq1[j];
  endfunction

  task automatic run_packet(input int inst, input string name);
    int b_we, b_cm, b_rb, b_dn, b_dr, b_fe, b_pe, maxp, cnt;
    bit dropped;
    logic [8:0] ew[$];
    int efe, epe;
    b_we = qsize(inst); b_cm = n_cm[inst]; b_rb = n_rb[inst]; b_dn = n_dn[inst];
    b_dr = n_dr[inst]; b_fe = n_fe[inst]; b_pe = n_pe[inst];
    for (int k = 0; k < pb.size(); k++) begin
      send_frame(inst, pb[k], pk[k]);
      if (k == 0 && pk[0] == 0) check({name, "_busy_open"}, 32'(bz[inst]), 32'd1);
    end
    repeat (IDLE_GAP + 3 * CPB) @(negedge clk);

    // Reference: bytes accepted in order until the first error or length overrun.
    maxp = (inst == 0) ? MAXP0 : MAXP1;
    cnt = 0; dropped = 1'b0; efe = 0; epe = 0;
    for (int k = 0; k < pb.size(); k++) begin
      if (pk[k] == 1) epe++;
      if (pk[k] == 2) efe++;
      if (!dropped) begin
        if (pk[k] != 0 || cnt == maxp) dropped = 1'b1;
        else begin
          ew.push_back({cnt == 0, pb[k]});
          cnt++;
        end
      end
    end

    check({name, "_nwr"}, 32'(qsize(inst) - b_we), 32'(ew.size()));
    for (int j = 0; j < ew.size() && b_we + j < qsize(inst); j++)
      check($sformatf("%s_wr%0d", name, j), 32'(qat(inst, b_we + j)), 32'(ew[j]));
    check({name, "_commit"}, 32'(n_cm[inst] - b_cm), 32'(!dropped && pb.size() > 0));
    check({name, "_rollback"}, 32'(n_rb[inst] - b_rb), 32'(dropped));
    check({name, "_pktdone"}, 32'(n_dn[inst] - b_dn), 32'(!dropped && pb.size() > 0));
    check({name, "_pktdropped"}, 32'(n_dr[inst] - b_dr), 32'(dropped));
    check({name, "_frameerr"}, 32'(n_fe[inst] - b_fe), 32'(efe));
    check({name, "_parityerr"}, 32'(n_pe[inst] - b_pe), 32'(epe));
    check({name, "_busy_closed"}, 32'(bz[inst]), 32'd0);
    if (!dropped && cnt > 0)
      check({name, "_commit_gap"}, 32'(last_cm[inst] - last_we[inst]), 32'(IDLE_GAP));
  endtask

  task automatic rand_packet(input int len);
    pb.delete(); pk.delete();
    for (int k = 0; k < len; k++) begin
      pb.push_back(8'($urandom));
      pk.push_back(0);
    end
  endtask

  int b_we, b_cm, b_rb, b_fe;

  initial begin
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_outputs%0d", i),
            32'({din[i], we[i], cm[i], rb[i], dn[i], dr[i], fe[i], pe[i], bz[i]}), 32'd0);
    repeat (4 * CPB) @(negedge clk);

    pb = '{8'h41, 8'h42, 8'h43}; pk = '{0, 0, 0};
    run_packet(0, "abc");

    for (int r = 0; r < 3; r++) begin
      rand_packet($urandom_range(1, MAXP0));
      run_packet(0, $sformatf("rand%0d", r));
    end

    rand_packet(5); pk[3] = 3;
    run_packet(0, "afull");

    rand_packet(MAXP0);
    run_packet(0, "maxlen");
    rand_packet(MAXP0 + 1);
    run_packet(0, "overlen");

    rand_packet(2); pk[1] = 2;
    run_packet(0, "frame");
    rand_packet(3);
    run_packet(0, "after_frame");

    rand_packet(3); pb[1] = 8'h03; pk[1] = 1;
    run_packet(1, "parity");
    rand_packet($urandom_range(1, 5));
    run_packet(1, "par_good");

    pb.delete(); pk.delete();
    rxd[0] = 1'b0;
    repeat (4) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy", 32'(bz[0]), 32'd0);
    run_packet(0, "glitch");

    // Reset in the middle of the second byte; no commit or rollback may follow.
    b_we = wq0.size(); b_cm = n_cm[0]; b_rb = n_rb[0]; b_fe = n_fe[0];
    send_frame(0, 8'($urandom), 0);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'($urandom));
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs",
          32'({din[0], we[0], cm[0], rb[0], dn[0], dr[0], fe[0], pe[0], bz[0]}), 32'd0);
    rxd[0] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (IDLE_GAP + 3 * CPB) @(negedge clk);
    check("midreset_nwr", 32'(wq0.size() - b_we), 32'd1);
    check("midreset_commit", 32'(n_cm[0] - b_cm), 32'd0);
    check("midreset_rollback", 32'(n_rb[0] - b_rb), 32'd0);
    check("midreset_frameerr", 32'(n_fe[0] - b_fe), 32'd0);

    rand_packet(2);
    run_packet(0, "post_reset");

    check("exclusivity", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
